// File: rtl/mem_access.sv
// mem_access: RV64 memory-access pipeline stage with req/ack data-memory bus
module mem_access #(
  parameter int XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            mem_read_i,
  input  logic            mem_write_i,
  input  logic            reg_write_i,
  input  logic [2:0]      funct3_i,
  input  logic [4:0]      rd_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic [XLEN-1:0] wr_ram_data_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [7:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_ack_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            stall_o,
  output logic [4:0]      rd_o,
  output logic            reg_write_o,
  output logic [XLEN-1:0] mem_result_o,
  output logic            misaligned_o
);
  typedef enum logic [1:0] {PASS, REQ, DONE, FAULT} state_t;
  state_t          state;
  logic            mem_read_r, mem_write_r, reg_write_r;
  logic [2:0]      funct3_r;
  logic [4:0]      rd_r;
  logic [XLEN-1:0] alu_r, wdata_r, load_r;
  logic            mis_n, fault_n, req;
  logic [7:0]      mask;
  logic [XLEN-1:0] shifted, ext;
  // decode of the incoming instruction: alignment and illegal-combination checks
  always_comb begin
    mis_n   = (funct3_i[1:0] == 2'b01 & alu_result_i[0]) |
              (funct3_i[1:0] == 2'b10 & |alu_result_i[1:0]) |
              (funct3_i[1:0] == 2'b11 & |alu_result_i[2:0]);
    fault_n = (mem_read_i & mem_write_i) | (mem_read_i & funct3_i == 3'b111) |
              (mem_write_i & funct3_i[2]) | ((mem_read_i | mem_write_i) & mis_n);
  end
  // lane steering of read data and load extension by access size/sign
  always_comb begin
    mask    = funct3_r[1:0] == 2'b00 ? 8'h01 : funct3_r[1:0] == 2'b01 ? 8'h03 :
              funct3_r[1:0] == 2'b10 ? 8'h0F : 8'hFF;
    shifted = dmem_rdata_i >> {alu_r[2:0], 3'b000};
    ext     = funct3_r == 3'b000 ? {{(XLEN-8){shifted[7]}}, shifted[7:0]} :
              funct3_r == 3'b001 ? {{(XLEN-16){shifted[15]}}, shifted[15:0]} :
              funct3_r == 3'b010 ? {{(XLEN-32){shifted[31]}}, shifted[31:0]} :
              funct3_r == 3'b100 ? {{(XLEN-8){1'b0}}, shifted[7:0]} :
              funct3_r == 3'b101 ? {{(XLEN-16){1'b0}}, shifted[15:0]} :
              funct3_r == 3'b110 ? {{(XLEN-32){1'b0}}, shifted[31:0]} : shifted;
  end
  // stage register and access FSM; the input register holds only while a request is outstanding
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= PASS;
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
      reg_write_r <= 1'b0;
      funct3_r    <= '0;
      rd_r        <= '0;
      alu_r       <= '0;
      wdata_r     <= '0;
      load_r      <= '0;
    end else if (state == REQ) begin
      if (dmem_ack_i) begin
        state <= DONE;
        if (mem_read_r) load_r <= ext;
      end
    end else begin
      mem_read_r  <= mem_read_i;
      mem_write_r <= mem_write_i;
      reg_write_r <= reg_write_i;
      funct3_r    <= funct3_i;
      rd_r        <= rd_i;
      alu_r       <= alu_result_i;
      wdata_r     <= wr_ram_data_i;
      state       <= fault_n ? FAULT : (mem_read_i | mem_write_i) ? REQ : PASS;
    end
  end
  // outputs derived purely from registered state; bus outputs are zero outside REQ
  always_comb begin
    req          = state == REQ;
    dmem_req_o   = req;
    dmem_we_o    = req & mem_write_r;
    dmem_addr_o  = req ? {alu_r[XLEN-1:3], 3'b000} : '0;
    dmem_be_o    = req ? mask << alu_r[2:0] : 8'h00;
    dmem_wdata_o = req ? wdata_r << {alu_r[2:0], 3'b000} : '0;
    stall_o      = req;
    rd_o         = rd_r;
    reg_write_o  = (state == PASS | state == DONE) & reg_write_r;
    mem_result_o = (state == DONE & mem_read_r) ? load_r : alu_r;
    misaligned_o = state == FAULT;
  end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed self-checking bench for the memory-access stage
module tb_mem_access;
  logic        clk = 0, rst = 1;
  logic        mem_read = 0, mem_write = 0, reg_write = 0, ack = 0;
  logic [2:0]  funct3 = 0;
  logic [4:0]  rd = 0;
  logic [63:0] alu = 0, wd = 0, rdata = 0;
  logic        req, we, stall, reg_write_o, mis;
  logic [63:0] addr, wdata, result;
  logic [7:0]  be;
  logic [4:0]  rd_o;
  int n_cmp = 0, n_fail = 0;

  mem_access dut (
    .clk_i(clk), .rst_i(rst), .mem_read_i(mem_read), .mem_write_i(mem_write),
    .reg_write_i(reg_write), .funct3_i(funct3), .rd_i(rd), .alu_result_i(alu),
    .wr_ram_data_i(wd), .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(addr),
    .dmem_be_o(be), .dmem_wdata_o(wdata), .dmem_ack_i(ack), .dmem_rdata_i(rdata),
    .stall_o(stall), .rd_o(rd_o), .reg_write_o(reg_write_o), .mem_result_o(result),
    .misaligned_o(mis)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic rw, input logic [2:0] f3,
                       input logic [4:0] d, input logic [63:0] a, input logic [63:0] s);
    mem_read = r; mem_write = w; reg_write = rw; funct3 = f3; rd = d; alu = a; wd = s;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b1, 3'b011, 5'd17, {$urandom, $urandom}, {$urandom, $urandom});
    ack = 1; rdata = {$urandom, $urandom};
    step(); step();
    chk("rst_req", req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_result", result, 0);
    chk("rst_regwr", reg_write_o, 0);
    chk("rst_rd", rd_o, 0);
    chk("rst_mis", mis, 0);
    chk("rst_be", be, 0);
    rst = 0; ack = 0;
    drive(1'b0, 1'b0, 1'b1, 3'b000, 5'd5, 64'h1234, 64'h0);
    step();
    chk("pass_result", result, 64'h1234);
    chk("pass_regwr", reg_write_o, 1);
    chk("pass_rd", rd_o, 5);
    chk("pass_stall", stall, 0);
    chk("pass_req", req, 0);
    drive(1'b1, 1'b0, 1'b1, 3'b010, 5'd7, 64'h1004, 64'h0);
    step();
    drive(1'b0, 1'b0, 1'b1, 3'b000, 5'd31, 64'hBAD, 64'h0);
    chk("lw_req", req, 1);
    chk("lw_addr", addr, 64'h1000);
    chk("lw_be", be, 8'hF0);
    chk("lw_we", we, 0);
    chk("lw_stall1", stall, 1);
    chk("lw_regwr_req", reg_write_o, 0);
    step();
    chk("lw_stall2", stall, 1);
    chk("lw_hold_addr", addr, 64'h1000);
    chk("lw_hold_rd", rd_o, 7);
    step();
    chk("lw_stall3", stall, 1);
    ack = 1; rdata = 64'h80000001_DEADBEEF;
    step();
    ack = 0;
    chk("lw_done_stall", stall, 0);
    chk("lw_done_req", req, 0);
    chk("lw_result", result, 64'hFFFFFFFF_80000001);
    chk("lw_done_regwr", reg_write_o, 1);
    chk("lw_done_rd", rd_o, 7);
    drive(1'b0, 1'b1, 1'b0, 3'b000, 5'd0, 64'h2003, 64'hAB);
    step();
    chk("sb_addr", addr, 64'h2000);
    chk("sb_we", we, 1);
    chk("sb_be", be, 8'h08);
    chk("sb_wdata", wdata, 64'h00000000_AB000000);
    chk("sb_regwr", reg_write_o, 0);
    chk("sb_stall", stall, 1);
    ack = 1;
    step();
    ack = 0;
    chk("sb_done_req", req, 0);
    chk("sb_done_result", result, 64'h2003);
    drive(1'b1, 1'b0, 1'b1, 3'b001, 5'd3, 64'h1001, 64'h0);
    step();
    chk("lh_mis", mis, 1);
    chk("lh_req", req, 0);
    chk("lh_regwr", reg_write_o, 0);
    chk("lh_stall", stall, 0);
    drive(1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 64'h55, 64'h0);
    step();
    chk("lh_mis_clear", mis, 0);
    chk("after_fault_result", result, 64'h55);
    drive(1'b1, 1'b0, 1'b1, 3'b100, 5'd9, 64'h7, 64'h0);
    step();
    chk("lbu_be", be, 8'h80);
    chk("lbu_addr", addr, 64'h0);
    ack = 1; rdata = 64'hF0123456_78ABCDEF;
    step();
    ack = 0;
    chk("lbu_result", result, 64'hF0);
    drive(1'b1, 1'b0, 1'b1, 3'b000, 5'd9, 64'h7, 64'h0);
    step();
    chk("lb_req", req, 1);
    ack = 1;
    step();
    ack = 0;
    chk("lb_result", result, 64'hFFFFFFFF_FFFFFFF0);
    drive(1'b1, 1'b0, 1'b1, 3'b011, 5'd4, 64'h3000, 64'h0);
    step();
    chk("rmid_req1", req, 1);
    step();
    chk("rmid_req2", req, 1);
    rst = 1; ack = 1; rdata = 64'h1111_2222_3333_4444;
    step();
    chk("rmid_req", req, 0);
    chk("rmid_stall", stall, 0);
    chk("rmid_result", result, 0);
    chk("rmid_regwr", reg_write_o, 0);
    rst = 0; ack = 0;
    drive(1'b0, 1'b1, 1'b0, 3'b100, 5'd0, 64'h4000, 64'hFF);
    step();
    chk("bad_store_mis", mis, 1);
    chk("bad_store_req", req, 0);
    chk("bad_store_we", we, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
